ntt_stage_sequencer: RTL and testbench

Butterfly-level scheduler for the NTT/INTT datapath. On a `start` pulse it walks all butterflies of an N-point transform stage by stage. For each butterfly it issues operand addresses and a twiddle index under a valid/ready handshake. For inverse transforms it runs the stages in reverse order and then appends an N-element scaling pass. It sits between the top-level transform control and the butterfly unit / coefficient RAM.

---
 rtl/ntt_stage_sequencer_if.sv | 27 ++
 rtl/ntt_stage_sequencer.sv | 114 +++++++++++
 tb/tb_ntt_stage_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_stage_sequencer_if.sv
// Handshake bundle between the NTT stage sequencer, the transform control and the butterfly datapath.
interface ntt_stage_sequencer_if #(
   parameter int LOG_N = 4
);
   logic             start;
   logic             inv;
   logic             dp_ready;
   logic             busy;
   logic             done;
   logic [2:0]       stage;
   logic             bf_valid;
   logic [LOG_N-1:0] addr_a;
   logic [LOG_N-1:0] addr_b;
   logic [LOG_N-2:0] tw_idx;
   logic             scale_valid;
   logic [LOG_N-1:0] scale_addr;

   modport master (
      input  start, inv, dp_ready,
      output busy, done, stage, bf_valid, addr_a, addr_b, tw_idx, scale_valid, scale_addr
   );

   modport slave (
      output start, inv, dp_ready,
      input  busy, done, stage, bf_valid, addr_a, addr_b, tw_idx, scale_valid, scale_addr
   );
endinterface

// File: rtl/ntt_stage_sequencer.sv
// Walks every butterfly of an N-point NTT/INTT stage by stage, with a trailing scale pass for INTT.
module ntt_stage_sequencer #(
   parameter int LOG_N = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   ntt_stage_sequencer_if.master seq_io
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] SCALE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [LOG_N-2:0] J_LAST     = {(LOG_N-1){1'b1}};
   localparam logic [LOG_N-1:0] I_LAST     = {LOG_N{1'b1}};
   localparam logic [2:0]       STAGE_LAST = 3'(LOG_N-1);

   logic [1:0]       state_q, state_d;
   logic [LOG_N-2:0] j_q, j_d;
   logic [2:0]       s_q, s_d;
   logic [LOG_N-1:0] i_q, i_d;
   logic             inv_q, inv_d;

   logic [LOG_N-2:0] kMask;
   logic [LOG_N-2:0] kIdx;
   logic [LOG_N-2:0] groupBits;
   logic [LOG_N-1:0] addrA;
   logic             lastStage;
   logic             bfValid;
   logic             scaleValid;

   // kMask = len-1 with len = N>>(s+1); the group bits of j sit above it and
   // shift up by one so that each group spans 2*len addresses.
   always_comb begin
      kMask     = J_LAST >> s_q;
      kIdx      = j_q & kMask;
      groupBits = j_q & ~kMask;
      addrA     = {groupBits, 1'b0} | {1'b0, kIdx};
      lastStage = inv_q ? (s_q == 3'd0) : (s_q == STAGE_LAST);
   end

   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      s_d     = s_q;
      i_d     = i_q;
      inv_d   = inv_q;
      case (state_q)
         IDLE: begin
            if (seq_io.start) begin
               state_d = RUN;
               inv_d   = seq_io.inv;
               j_d     = '0;
               s_d     = seq_io.inv ? STAGE_LAST : 3'd0;
            end
         end
         RUN: begin
            if (seq_io.dp_ready) begin
               if (j_q != J_LAST) begin
                  j_d = j_q + 1'b1;
               end else begin
                  j_d = '0;
                  if (lastStage) begin
                     state_d = inv_q ? SCALE : DONE;
                     i_d     = '0;
                  end else begin
                     s_d = inv_q ? (s_q - 3'd1) : (s_q + 3'd1);
                  end
               end
            end
         end
         SCALE: begin
            if (seq_io.dp_ready) begin
               if (i_q == I_LAST) begin
                  state_d = DONE;
                  i_d     = '0;
               end else begin
                  i_d = i_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         j_q     <= '0;
         s_q     <= '0;
         i_q     <= '0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         s_q     <= s_d;
         i_q     <= i_d;
         inv_q   <= inv_d;
      end
   end

   // Every output is a pure decode of registered state and forced to 0 when its valid is low.
   assign bfValid              = (state_q == RUN);
   assign scaleValid           = (state_q == SCALE);
   assign seq_io.busy          = (state_q != IDLE);
   assign seq_io.done          = (state_q == DONE);
   assign seq_io.bf_valid      = bfValid;
   assign seq_io.scale_valid   = scaleValid;
   assign seq_io.stage         = bfValid ? s_q : 3'd0;
   assign seq_io.addr_a        = bfValid ? addrA : '0;
   assign seq_io.addr_b        = bfValid ? (addrA + {1'b0, kMask} + LOG_N'(1)) : '0;
   assign seq_io.tw_idx        = bfValid ? (kIdx << s_q) : '0;
   assign seq_io.scale_addr    = scaleValid ? i_q : '0;
endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Self-checking bench: a queue-based transaction model of the whole transform plus literal timing checks.
module tb_ntt_stage_sequencer;
   localparam int LOG_N = 4;
   localparam int N     = 1 << LOG_N;

   typedef struct {
      bit isScale;
      int stg;
      int a;
      int b;
      int tw;
   } beat_t;

   logic clk;
   logic rst_n;

   int checkCount = 0;
   int errorCount = 0;
   int dutDones   = 0;
   int modelDones = 0;

   beat_t expQ[$];
   bit    busyM = 0;
   bit    doneM = 0;

   ntt_stage_sequencer_if #(.LOG_N(LOG_N)) seqIf ();

   ntt_stage_sequencer #(.LOG_N(LOG_N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .seq_io(seqIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // The whole beat list of one transform, straight from the division/modulo address rules.
   function automatic void buildRun(input bit invDir);
      for (int n = 0; n < LOG_N; n++) begin
         int s = invDir ? (LOG_N - 1 - n) : n;
         for (int j = 0; j < N / 2; j++) begin
            beat_t bt;
            int len = N >> (s + 1);
            int g   = j / len;
            int k   = j % len;
            bt.isScale = 0;
            bt.stg     = s;
            bt.a       = 2 * g * len + k;
            bt.b       = bt.a + len;
            bt.tw      = (k << s) % (N / 2);
            expQ.push_back(bt);
         end
      end
      if (invDir) begin
         for (int i = 0; i < N; i++) begin
            beat_t bt;
            bt.isScale = 1;
            bt.stg     = 0;
            bt.a       = i;
            bt.b       = 0;
            bt.tw      = 0;
            expQ.push_back(bt);
         end
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         expQ.delete();
         busyM = 0;
         doneM = 0;
      end else if (doneM) begin
         doneM = 0;
         busyM = 0;
      end else if (busyM) begin
         if (seqIf.dp_ready) begin
            void'(expQ.pop_front());
            if (expQ.size() == 0) doneM = 1;
         end
      end else if (seqIf.start) begin
         buildRun(seqIf.inv);
         busyM = 1;
      end
   end

   int expBf, expSc, expStage, expA, expB, expTw, expSa;

   always @(negedge clk) begin
      expBf = 0; expSc = 0; expStage = 0; expA = 0; expB = 0; expTw = 0; expSa = 0;
      if (busyM && !doneM && expQ.size() > 0) begin
         if (expQ[0].isScale) begin
            expSc = 1;
            expSa = expQ[0].a;
         end else begin
            expBf    = 1;
            expStage = expQ[0].stg;
            expA     = expQ[0].a;
            expB     = expQ[0].b;
            expTw    = expQ[0].tw;
         end
      end
      dutDones   += int'(seqIf.done);
      modelDones += int'(doneM);
      checkOutput("busy",        int'(seqIf.busy),        int'(busyM));
      checkOutput("done",        int'(seqIf.done),        int'(doneM));
      checkOutput("bf_valid",    int'(seqIf.bf_valid),    expBf);
      checkOutput("scale_valid", int'(seqIf.scale_valid), expSc);
      checkOutput("stage",       int'(seqIf.stage),       expStage);
      checkOutput("addr_a",      int'(seqIf.addr_a),      expA);
      checkOutput("addr_b",      int'(seqIf.addr_b),      expB);
      checkOutput("tw_idx",      int'(seqIf.tw_idx),      expTw);
      checkOutput("scale_addr",  int'(seqIf.scale_addr),  expSa);
   end

   // Inputs change 2 time units after a rising edge, so they are stable for that whole cycle.
   task automatic applyStimulus(input bit st, input bit iv, input bit rdy);
      @(posedge clk);
      #2;
      seqIf.start    = st;
      seqIf.inv      = iv;
      seqIf.dp_ready = rdy;
   endtask

   task automatic doReset();
      @(posedge clk);
      #2;
      rst_n          = 1'b0;
      seqIf.start    = 1'b0;
      seqIf.dp_ready = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // Starts one transform; returns at the falling edge of cycle t+1.
   task automatic launch(input bit iv);
      applyStimulus(1, iv, 1);
      applyStimulus(0, iv, 1);
      @(negedge clk);
   endtask

   task automatic literalNtt();
      doReset();
      launch(0);
      for (int c = 1; c <= 34; c++) begin
         if (c == 1) begin
            checkOutput("lit_ntt_c1_stage", int'(seqIf.stage), 0);
            checkOutput("lit_ntt_c1_a", int'(seqIf.addr_a), 0);
            checkOutput("lit_ntt_c1_b", int'(seqIf.addr_b), 8);
            checkOutput("lit_ntt_c1_tw", int'(seqIf.tw_idx), 0);
         end
         if (c == 2) begin
            checkOutput("lit_ntt_c2_a", int'(seqIf.addr_a), 1);
            checkOutput("lit_ntt_c2_b", int'(seqIf.addr_b), 9);
            checkOutput("lit_ntt_c2_tw", int'(seqIf.tw_idx), 1);
         end
         if (c == 13) begin
            checkOutput("lit_ntt_c13_stage", int'(seqIf.stage), 1);
            checkOutput("lit_ntt_c13_a", int'(seqIf.addr_a), 8);
            checkOutput("lit_ntt_c13_b", int'(seqIf.addr_b), 12);
            checkOutput("lit_ntt_c13_tw", int'(seqIf.tw_idx), 0);
         end
         if (c == 14) begin
            checkOutput("lit_ntt_c14_a", int'(seqIf.addr_a), 9);
            checkOutput("lit_ntt_c14_b", int'(seqIf.addr_b), 13);
            checkOutput("lit_ntt_c14_tw", int'(seqIf.tw_idx), 2);
         end
         if (c >= 25 && c <= 32) begin
            checkOutput("lit_ntt_s3_stage", int'(seqIf.stage), 3);
            checkOutput("lit_ntt_s3_a", int'(seqIf.addr_a), 2 * (c - 25));
            checkOutput("lit_ntt_s3_b", int'(seqIf.addr_b), 2 * (c - 25) + 1);
            checkOutput("lit_ntt_s3_tw", int'(seqIf.tw_idx), 0);
         end
         checkOutput("lit_ntt_done", int'(seqIf.done), (c == 33) ? 1 : 0);
         checkOutput("lit_ntt_busy", int'(seqIf.busy), (c <= 33) ? 1 : 0);
         applyStimulus(0, 0, 1);
         @(negedge clk);
      end
   endtask

   task automatic literalIntt();
      doReset();
      launch(1);
      for (int c = 1; c <= 50; c++) begin
         if (c == 1) begin
            checkOutput("lit_intt_c1_stage", int'(seqIf.stage), 3);
            checkOutput("lit_intt_c1_a", int'(seqIf.addr_a), 0);
            checkOutput("lit_intt_c1_b", int'(seqIf.addr_b), 1);
         end
         if (c == 25) begin
            checkOutput("lit_intt_c25_stage", int'(seqIf.stage), 0);
            checkOutput("lit_intt_c25_a", int'(seqIf.addr_a), 0);
            checkOutput("lit_intt_c25_b", int'(seqIf.addr_b), 8);
         end
         checkOutput("lit_intt_bf_valid", int'(seqIf.bf_valid), (c <= 32) ? 1 : 0);
         checkOutput("lit_intt_scale_valid", int'(seqIf.scale_valid), (c >= 33 && c <= 48) ? 1 : 0);
         if (c >= 33 && c <= 48) checkOutput("lit_intt_scale_addr", int'(seqIf.scale_addr), c - 33);
         checkOutput("lit_intt_done", int'(seqIf.done), (c == 49) ? 1 : 0);
         applyStimulus(0, 1, 1);
         @(negedge clk);
      end
   endtask

   task automatic literalStall();
      int holdA;
      doReset();
      launch(0);
      holdA = 0;
      for (int c = 1; c <= 37; c++) begin
         if (c == 5) holdA = int'(seqIf.addr_a);
         if (c >= 6 && c <= 8) checkOutput("lit_stall_hold_a", int'(seqIf.addr_a), holdA);
         if (c == 8) checkOutput("lit_stall_beat5_a", int'(seqIf.addr_a), 4);
         if (c == 9) checkOutput("lit_stall_beat6_a", int'(seqIf.addr_a), 5);
         checkOutput("lit_stall_done", int'(seqIf.done), (c == 36) ? 1 : 0);
         applyStimulus(0, 0, (c + 1 >= 5 && c + 1 <= 7) ? 1'b0 : 1'b1);
         @(negedge clk);
      end
   endtask

   task automatic literalStartDuringRun();
      int windowDones;
      doReset();
      launch(0);
      windowDones = 0;
      for (int c = 1; c <= 40; c++) begin
         windowDones += int'(seqIf.done);
         if (c == 20) checkOutput("lit_ignore_stage", int'(seqIf.stage), 2);
         checkOutput("lit_ignore_done", int'(seqIf.done), (c == 33) ? 1 : 0);
         applyStimulus((c + 1 == 5) || (c + 1 == 33), c[0], 1);
      end
      checkOutput("lit_ignore_done_count", windowDones, 1);
   endtask

   task automatic literalResetMidRun();
      int cyc;
      doReset();
      launch(0);
      for (int c = 1; c < 10; c++) begin
         applyStimulus(0, 0, 1);
         @(negedge clk);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("lit_rst_busy", int'(seqIf.busy), 0);
      checkOutput("lit_rst_bf_valid", int'(seqIf.bf_valid), 0);
      checkOutput("lit_rst_addr_b", int'(seqIf.addr_b), 0);
      checkOutput("lit_rst_stage", int'(seqIf.stage), 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      launch(0);
      cyc = 0;
      while (!seqIf.done && cyc < 200) begin
         applyStimulus(0, 0, 1'($urandom_range(0, 3) != 0));
         @(negedge clk);
         cyc++;
      end
      checkOutput("lit_rst_rerun_done", int'(seqIf.done), 1);
   endtask

   initial begin
      rst_n          = 1'b0;
      seqIf.start    = 1'b0;
      seqIf.inv      = 1'b0;
      seqIf.dp_ready = 1'b0;
      #1;
      checkOutput("reset_busy", int'(seqIf.busy), 0);
      checkOutput("reset_addr_b", int'(seqIf.addr_b), 0);
      literalNtt();
      literalIntt();
      literalStall();
      literalStartDuringRun();
      literalResetMidRun();
      doReset();
      for (int c = 0; c < 4000; c++) begin
         if (c >= 1500 && c < 1700) begin
            applyStimulus(1, 0, 1);
         end else if ($urandom_range(0, 399) == 0) begin
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            applyStimulus(0, 1'($urandom_range(0, 1)), 1);
            rst_n = 1'b1;
         end else begin
            applyStimulus(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) != 0));
         end
      end
      applyStimulus(0, 0, 1);
      @(negedge clk);
      checkOutput("done_count", dutDones, modelDones);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end
endmodule
